// File: rtl/mssd_tx_scheduler.sv
// ---------------------------------------------------------------------------
// mssd_tx_scheduler
//
// Transmit-side scheduler for the serial demux link. Four channels share one
// serial line; a round-robin arbiter picks one requesting channel at a time
// and the scheduler serialises one frame for it:
//
//   start bit (0) | port number (PORT_W, MSB first) | length (LEN_W, MSB first)
//   | len data bits | GAP idle ones
//
// Ports
//   clk_en     : clock, all state updates on its rising edge
//   rst        : asynchronous, active-high reset
//   req        : per-channel request level
//   len_in     : packed per-channel frame length, channel k at [k*LEN_W +: LEN_W]
//   data_in    : per-channel serial data bit, taken when that channel's bit_rd is high
//   gnt        : one-hot grant, held from the start bit through the last data bit
//   bit_rd     : one-hot data-pop strobe (combinational from registered state)
//   ser_out    : registered serial link line, idles at 1
//   busy       : high from the start bit through the end of the gap
//   done       : one-cycle pulse in the first gap cycle
//   state_dbg  : current FSM state, for observation only
//
// Channel handshake: req is a level, sampled only while the scheduler is
// idle. gnt rising is the acknowledge; once granted, the channel index and
// its length are latched, so later changes of req or len_in have no effect on
// the frame in flight. While gnt[k] is high, every cycle with bit_rd[k] high
// consumes exactly one bit: data_in[k] is registered into ser_out at the end
// of that cycle and the source must present its next bit afterwards.
// ---------------------------------------------------------------------------
module mssd_tx_scheduler #(
    parameter int PORT_W = 2,
    parameter int LEN_W  = 4,
    parameter int GAP    = 1
) (
    input  logic                            clk_en,
    input  logic                            rst,
    input  logic [(2**PORT_W)-1:0]          req,
    input  logic [(2**PORT_W)*LEN_W-1:0]    len_in,
    input  logic [(2**PORT_W)-1:0]          data_in,
    output logic [(2**PORT_W)-1:0]          gnt,
    output logic [(2**PORT_W)-1:0]          bit_rd,
    output logic                            ser_out,
    output logic                            busy,
    output logic                            done,
    output logic [2:0]                      state_dbg
);

    localparam int NCH   = 2**PORT_W;
    localparam int HDR_W = PORT_W + LEN_W;
    // Wide enough for every phase length (PORT_W, LEN_W, 2**LEN_W-1, GAP).
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_PORT  = 3'd2,
        S_LEN   = 3'd3,
        S_DATA  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;      // cycle index inside the current phase
    logic [PORT_W-1:0]   ch_q;     // granted channel
    logic [LEN_W-1:0]    len_q;    // latched frame length
    logic [PORT_W-1:0]   last_q;   // last granted channel (round-robin pointer)
    logic [HDR_W-1:0]    hdr_q;    // header shift register {port, len}, MSB out first

    // -----------------------------------------------------------------------
    // Round-robin arbitration: first requester searching upward from
    // last_q+1, wrapping through the channel count.
    // -----------------------------------------------------------------------
    logic                arb_found;
    logic [PORT_W-1:0]   arb_idx;
    logic [PORT_W-1:0]   arb_cand;
    logic [LEN_W-1:0]    arb_len;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last_q;
        arb_cand  = '0;
        for (int i = 1; i <= NCH; i++) begin
            // Modular add wraps naturally in PORT_W bits.
            arb_cand = last_q + PORT_W'(i);
            if (!arb_found && req[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
        arb_len = len_in[arb_idx*LEN_W +: LEN_W];
    end

    // -----------------------------------------------------------------------
    // Phase-end decodes.
    // -----------------------------------------------------------------------
    logic port_last;
    logic len_last;
    logic data_last;
    logic gap_last;
    logic len_zero;

    assign port_last = (cnt == CNT_W'(PORT_W - 1));
    assign len_last  = (cnt == CNT_W'(LEN_W - 1));
    assign data_last = (cnt == (CNT_W'(len_q) - CNT_W'(1)));
    assign gap_last  = (cnt == CNT_W'(GAP - 1));
    assign len_zero  = (len_q == '0);

    // A data bit is popped one cycle ahead of its appearance on ser_out:
    // in the last length cycle (first data bit) and in every data cycle
    // except the last one.
    logic pop_en;

    assign pop_en = ((state == S_LEN)  && len_last && !len_zero) ||
                    ((state == S_DATA) && !data_last);

    // gnt is one-hot for the granted channel, so masking it keeps bit_rd
    // one-hot and a subset of gnt by construction.
    assign bit_rd    = pop_en ? gnt : '0;
    assign state_dbg = state;

    // -----------------------------------------------------------------------
    // Frame FSM with registered outputs. ser_out always shows the bit that
    // belongs to the state currently held, so each transition loads the
    // first bit of the next phase.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_en or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ch_q    <= '0;
            len_q   <= '0;
            last_q  <= PORT_W'(NCH - 1);
            hdr_q   <= '0;
            ser_out <= 1'b1;
            gnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    ser_out <= 1'b1;
                    if (arb_found) begin
                        state   <= S_START;
                        cnt     <= '0;
                        ch_q    <= arb_idx;
                        len_q   <= arb_len;
                        last_q  <= arb_idx;
                        hdr_q   <= {arb_idx, arb_len};
                        gnt     <= NCH'(1) << arb_idx;
                        busy    <= 1'b1;
                        ser_out <= 1'b0;    // start bit
                    end
                end

                S_START: begin
                    state   <= S_PORT;
                    cnt     <= '0;
                    ser_out <= hdr_q[HDR_W-1];
                    hdr_q   <= hdr_q << 1;
                end

                S_PORT: begin
                    // The header register runs straight on from port into
                    // length, so every port cycle shifts one bit out.
                    ser_out <= hdr_q[HDR_W-1];
                    hdr_q   <= hdr_q << 1;
                    if (port_last) begin
                        state <= S_LEN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_LEN: begin
                    if (len_last) begin
                        cnt <= '0;
                        if (len_zero) begin
                            state   <= S_GAP;
                            ser_out <= 1'b1;
                            gnt     <= '0;
                            done    <= 1'b1;
                        end else begin
                            state   <= S_DATA;
                            ser_out <= data_in[ch_q];
                        end
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        ser_out <= hdr_q[HDR_W-1];
                        hdr_q   <= hdr_q << 1;
                    end
                end

                S_DATA: begin
                    if (data_last) begin
                        state   <= S_GAP;
                        cnt     <= '0;
                        ser_out <= 1'b1;
                        gnt     <= '0;
                        done    <= 1'b1;
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        ser_out <= data_in[ch_q];
                    end
                end

                S_GAP: begin
                    ser_out <= 1'b1;
                    if (gap_last) begin
                        // Requests pending now are arbitrated on the next
                        // edge, giving one idle cycle between frames.
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    ser_out <= 1'b1;
                    gnt     <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mssd_tx_scheduler.md
Name: mssd_tx_scheduler

Overview:
- Transmit-side scheduler for the serial demultiplexer link. It shares one serial output line among four requesting channels using round-robin arbitration.
- For each granted channel it builds one frame: start bit, port number, data length, then the channel's data bits. This is the format the receiving demux controller decodes.
- It sits between the channel sources and the link and is the only driver of the link line.

Parameters:
- PORT_W, 2, width of the port-number field (number of channels = 2**PORT_W = 4; only 2 is supported).
- LEN_W, 4, width of the length field; maximum data bits per frame = 2**LEN_W-1.
- GAP, 1, idle-'1' cycles forced after every frame (must be >= 1).

Ports:
- clk_en  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-channel request level.
- len_in  input  4*LEN_W  packed per-channel frame length; channel k occupies bits [k*LEN_W +: LEN_W].
- data_in  input  4  per-channel serial data bit, sampled when that channel's bit_rd is high.
- gnt  output  4  one-hot grant, held for the whole frame.
- bit_rd  output  4  one-hot data-pop strobe, combinational.
- ser_out  output  1  registered serial link line; idles at 1.
- busy  output  1  high from the START state through the end of GAP.
- done  output  1  one-cycle pulse in the first GAP cycle.

Behaviour:
- Reset values: ser_out=1, gnt=0, bit_rd=0, busy=0, done=0, state=IDLE.
  - The round-robin pointer resets to "last granted = 3", so channel 0 has highest priority first.
- States and transitions:
  - IDLE -> START when any req bit is high.
  - START: 1 cycle.
  - PORT: PORT_W cycles.
  - LEN: LEN_W cycles.
  - DATA: len cycles.
  - GAP: GAP cycles, then back to IDLE.
- Arbitration (in IDLE only):
  - Pick the first requesting channel searching from last_granted+1 upward, wrapping from 3 to 0.
  - At the same edge, latch the channel index and its len_in value, update the pointer, and set gnt.
- Timing, with cycle c = the cycle whose ending edge sees req while in IDLE:
  - c+1: ser_out=0 (start bit); gnt and busy rise.
  - Next PORT_W cycles: port number, MSB first.
  - Next LEN_W cycles: latched length, MSB first.
  - Next len cycles: data bits.
- Data pop:
  - bit_rd[ch]=1 during the cycle before each data bit appears on ser_out, i.e. the last LEN cycle and every DATA cycle except the last.
  - data_in[ch] is registered into ser_out at the end of that cycle, so each bit is popped exactly once.
- Length zero: the header is sent with length field 0, there is no DATA state, bit_rd never pulses, and the block goes straight to GAP.
- GAP: ser_out=1, gnt=0, busy=1; done=1 in the first GAP cycle only.
- Back-to-back frames: a request held during GAP is arbitrated on the edge after GAP completes. Minimum spacing is 1 start bit + PORT_W + LEN_W + len + GAP + 1 IDLE cycle.
- req or len_in changing mid-frame: ignored, because the channel and length were latched at grant. A dropped request does not abort the frame.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronously). The frame is truncated with ser_out=1 and the pointer returns to 3.
- Fixed invariants:
  - gnt and bit_rd are always one-hot or zero.
  - bit_rd is a subset of gnt.
  - ser_out equals 1 whenever the state is IDLE or GAP.

Test Plan:
- Single request: ch2 with len=3, data stream 1,0,1. ser_out from c+1 must read 0,1,0,0,0,1,1,1,0,1, then 1. bit_rd[2] pulses 3 times, done pulses once, gnt=4'b0100 for 10 cycles.
- Contention: req=4'b1111 held with every len=1. Grant order must be 0,1,2,3,0, with each frame starting exactly 1+2+4+1+GAP+1 cycles after the previous one.
- Zero length: ch1 with len=0. ser_out must read 0,0,1,0,0,0,0, then idle; bit_rd stays 0; done still pulses.
- Dropped request: ch3 len=5, req deasserted in the second PORT cycle. The full frame still completes with 5 data bits and the port field reads 1,1.
- Reset mid-DATA: rst asserted in data bit 2 of a len=7 frame. ser_out=1 and gnt=0 in the same cycle. After release, simultaneous req[3] and req[0] gives the grant to ch0.
- GAP=3 with back-to-back ch0 requests: exactly 3 ones after the last data bit plus 1 IDLE cycle before the next start bit.
